argmax_decision: RTL and testbench
==================================

Name: argmax_decision

Overview:
Final classification stage of the MNIST recogniser. It sits directly downstream of the output fully-connected layer and consumes that layer's 10 class scores, one signed score per cycle. It tracks the running maximum and emits the winning digit on `decision` with a one-cycle `finish` pulse, which drives the `decision`/`finish` outputs of `top`.

Parameters:
- NUM_CLASSES, 10, number of scores per frame; class index equals the beat position 0..NUM_CLASSES-1.
- SCORE_W, 24, width of the signed two's-complement score.
- IDX_W, 4, width of `decision`; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- score_valid, input, 1: score_data/score_last valid this cycle; always accepted (no backpressure).
- score_data, input, SCORE_W: signed class score.
- score_last, input, 1: marks the final score of a frame.
- decision, output, IDX_W: index of the maximum score of the last good frame; held until the next good frame.
- max_score, output, SCORE_W: the winning score; updated together with `decision`.
- finish, output, 1: one-cycle pulse; `decision` and `max_score` are valid in the same cycle.
- error, output, 1: sticky framing-error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): decision=0, max_score=0, finish=0, error=0, beat count=0, best=0, best_idx=0, state=IDLE.
- States: IDLE (no frame in progress) and ACCUM (beats 1..NUM_CLASSES-1 expected).
- IDLE, score_valid=1:
  - best<=score_data, best_idx<=0, count<=1, go to ACCUM.
  - If score_last=1 on this beat and NUM_CLASSES>1: framing error (see below).
- ACCUM, score_valid=1:
  - Compare signed. Update best/best_idx<=count only if score_data > best (strictly greater).
  - Ties keep the lower index.
  - count<=count+1.
- ACCUM, score_valid=0: hold all state. Gaps between beats of any length are allowed.
- Final beat (count==NUM_CLASSES-1 with score_last=1):
  - On that edge, register decision and max_score from the argmax that includes this beat.
  - Assert finish for exactly one cycle, return to IDLE, count<=0.
  - Latency: finish is high in the cycle immediately after the final beat is presented.
- Back-to-back frames: a score_valid in the cycle finish is high is accepted as beat 0 of the next frame. No dead cycle.
- Framing error, either case:
  - score_last=1 on a beat with index != NUM_CLASSES-1;
  - the beat with index NUM_CLASSES-1 arrives with score_last=0.
- On a framing error:
  - error<=1 (sticky), no finish, decision/max_score unchanged.
  - Frame discarded, state<=IDLE, count<=0.
  - The next valid beat starts a fresh frame.
- Comparison uses full SCORE_W signed arithmetic. No saturation or truncation. Most-negative value handled correctly.
- Reset asserted mid-frame: immediate return to reset values; partial frame lost; finish never asserted for it.
- finish never asserts for two consecutive cycles.

Test Plan:
- Scores 5,-3,12,7,0,1,2,3,4,11 (last on beat 9), contiguous -> finish one cycle after beat 9; decision=2, max_score=12.
- All ten scores = -100 -> decision=0 (tie, lowest index wins), max_score=-100.
- Scores all -8388608 except beat 9 = -1, with 3-cycle gaps between beats -> decision=9, max_score=-1; finish exactly once.
- Two frames back-to-back, second frame's beat 0 presented in the finish cycle; second frame peak 50 at index 6 -> second finish 10 cycles after the first; decision=6.
- score_last on beat 4 -> error=1, no finish, decision keeps its prior value; following good frame with max at index 3 -> finish, decision=3, error stays 1.
- rst_n pulsed low after beat 5 of a frame -> all outputs 0 immediately; a new complete frame with max at index 7 -> decision=7.

Source files
------------

// File: rtl/argmax_decision.sv
// rtl/argmax_decision.sv - streaming argmax over one frame of signed class scores
// Tracks the running maximum per frame and reports the winning index with a one-cycle finish pulse.
module argmax_decision #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 24,
  parameter int IDX_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      score_valid,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic        [IDX_W-1:0]   decision,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      finish,
  output logic                      error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                    state_q, state_d;
  logic        [IDX_W-1:0]   count_q, count_d;
  logic        [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic        [IDX_W-1:0]   decision_q, decision_d;
  logic signed [SCORE_W-1:0] max_score_q, max_score_d;
  logic                      finish_q, finish_d;
  logic                      error_q, error_d;

  logic        [IDX_W-1:0]   beat_idx;
  logic                      take_new;
  logic        [IDX_W-1:0]   cand_idx;
  logic signed [SCORE_W-1:0] cand_best;

  // Beat 0 always seeds the maximum; later beats win only when strictly greater,
  // so ties keep the lower index.
  always_comb begin
    beat_idx  = (state_q == IDLE) ? '0 : count_q;
    take_new  = (state_q == IDLE) || (score_data > best_q);
    cand_best = take_new ? score_data : best_q;
    cand_idx  = take_new ? beat_idx : best_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    decision_d  = decision_q;
    max_score_d = max_score_q;
    finish_d    = 1'b0;
    error_d     = error_q;

    if (score_valid) begin
      state_d = IDLE;
      count_d = '0;
      if (beat_idx == LAST_IDX) begin
        if (score_last) begin
          decision_d  = cand_idx;
          max_score_d = cand_best;
          finish_d    = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end else if (score_last) begin
        error_d = 1'b1;
      end else begin
        state_d    = ACCUM;
        count_d    = beat_idx + 1'b1;
        best_d     = cand_best;
        best_idx_d = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      decision_q  <= '0;
      max_score_q <= '0;
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      decision_q  <= decision_d;
      max_score_q <= max_score_d;
      finish_q    <= finish_d;
      error_q     <= error_d;
    end
  end

  assign decision  = decision_q;
  assign max_score = max_score_q;
  assign finish    = finish_q;
  assign error     = error_q;

endmodule

// File: tb/tb_argmax_decision.sv
// tb/tb_argmax_decision.sv - directed and randomized checks of argmax_decision against a frame-level model
module tb_argmax_decision;

  typedef logic signed [23:0] score_t;
  typedef score_t frame_t [10];
  typedef int     iframe_t [10];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        score_valid;
  score_t      score_data;
  logic        score_last;
  logic [3:0]  decision;
  score_t      max_score;
  logic        finish;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  int     cyc = 0;
  int     fin_cnt = 0;
  int     consec = 0;
  logic   prev_fin = 1'b0;
  int     fin_cyc_q[$];

  int     exp_dec = 0;
  score_t exp_max = '0;

  argmax_decision #(.NUM_CLASSES(10), .SCORE_W(24), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score_valid(score_valid),
    .score_data (score_data),
    .score_last (score_last),
    .decision   (decision),
    .max_score  (max_score),
    .finish     (finish),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (finish === 1'b1) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc_q.push_back(cyc);
      if (prev_fin) consec <= consec + 1;
    end
    prev_fin <= (finish === 1'b1);
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t to_frame(input iframe_t a);
    frame_t f;
    foreach (a[i]) f[i] = score_t'(a[i]);
    return f;
  endfunction

  // Reference: find the maximum value, then the first position holding it.
  function automatic void model(input frame_t s, output int idx, output score_t mx);
    mx = s[0];
    foreach (s[i]) if (s[i] > mx) mx = s[i];
    idx = -1;
    foreach (s[i]) if (idx < 0 && s[i] == mx) idx = i;
  endfunction

  task automatic drive(input logic v, input score_t d, input logic l);
    @(negedge clk);
    #1;
    score_valid = v;
    score_data  = d;
    score_last  = l;
  endtask

  task automatic send(input frame_t s, input int n, input int last_pos, input int gap, output int lbc);
    lbc = -1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, s[i], i == last_pos);
      lbc = cyc;
      if (i < n - 1)
        for (int g = 0; g < gap; g++) drive(1'b0, score_t'($urandom), 1'b0);
    end
  endtask

  function automatic int last_fin_cyc();
    return (fin_cyc_q.size() > 0) ? fin_cyc_q[fin_cyc_q.size()-1] : -1;
  endfunction

  // Called one cycle after the final beat, with inputs already idle.
  task automatic check_good(input string tag, input frame_t s, input int lbc, input int fin_before);
    int idx;
    score_t mx;
    model(s, idx, mx);
    exp_dec = idx;
    exp_max = mx;
    chk({tag, "_fin_cnt"}, fin_cnt, fin_before + 1);
    chk({tag, "_latency"}, last_fin_cyc(), lbc + 1);
    chk({tag, "_finish_hi"}, finish, 1);
    chk({tag, "_decision"}, decision, idx);
    chk({tag, "_max_score"}, max_score, mx);
    drive(1'b0, '0, 1'b0);
    chk({tag, "_finish_lo"}, finish, 0);
  endtask

  initial begin
    frame_t s, s2;
    int     lbc, lbc2, fb, idx_a;
    score_t mx_a;

    rst_n = 1'b0;
    score_valid = 1'b0;
    score_data = '0;
    score_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_decision", decision, 0);
    chk("rst_max_score", max_score, 0);
    chk("rst_finish", finish, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);

    // Contiguous frame, peak 12 at index 2
    s = to_frame('{5, -3, 12, 7, 0, 1, 2, 3, 4, 11});
    fb = fin_cnt;
    send(s, 10, 9, 0, lbc);
    drive(1'b0, '0, 1'b0);
    check_good("t1", s, lbc, fb);
    chk("t1_dec_const", decision, 2);
    chk("t1_max_const", max_score, 12);

    // All equal: lowest index wins
    s = to_frame('{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100});
    fb = fin_cnt;
    send(s, 10, 9, 0, lbc);
    drive(1'b0, '0, 1'b0);
    check_good("t2_tie", s, lbc, fb);

    // Most-negative scores with gaps; winner on final beat
    s = to_frame('{-8388608, -8388608, -8388608, -8388608, -8388608,
                   -8388608, -8388608, -8388608, -8388608, -1});
    fb = fin_cnt;
    send(s, 10, 9, 3, lbc);
    drive(1'b0, '0, 1'b0);
    check_good("t3_neg", s, lbc, fb);
    chk("t3_dec_const", decision, 9);
    repeat (3) drive(1'b0, '0, 1'b0);
    chk("t3_once", fin_cnt, fb + 1);

    // Back-to-back frames: second frame's beat 0 lands in the finish cycle
    foreach (s[i]) s[i] = score_t'($urandom);
    foreach (s2[i]) s2[i] = score_t'(int'($urandom_range(0, 249)) - 200);
    s2[6] = 24'sd50;
    model(s, idx_a, mx_a);
    fb = fin_cnt;
    send(s, 10, 9, 0, lbc);
    send(s2, 10, 9, 0, lbc2);
    chk("t4_first_fin", fin_cnt, fb + 1);
    chk("t4_first_lat", last_fin_cyc(), lbc + 1);
    drive(1'b0, '0, 1'b0);
    chk("t4_fin_cnt", fin_cnt, fb + 2);
    chk("t4_spacing", last_fin_cyc() - fin_cyc_q[fin_cyc_q.size()-2], 10);
    check_good("t4_second", s2, lbc2, fb + 1);
    chk("t4_dec_const", decision, 6);

    // Early score_last on beat 4 is a framing error
    foreach (s[i]) s[i] = score_t'($urandom);
    fb = fin_cnt;
    send(s, 5, 4, 0, lbc);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("t5_error", error, 1);
    chk("t5_no_finish", fin_cnt, fb);
    chk("t5_dec_held", decision, exp_dec);
    chk("t5_max_held", max_score, exp_max);
    foreach (s[i]) s[i] = score_t'(int'($urandom_range(0, 1999)) - 1000);
    s[3] = 24'sd5000;
    fb = fin_cnt;
    send(s, 10, 9, 1, lbc);
    drive(1'b0, '0, 1'b0);
    check_good("t5_recover", s, lbc, fb);
    chk("t5_error_sticky", error, 1);

    // Reset mid-frame after beat 5
    foreach (s[i]) s[i] = score_t'($urandom);
    fb = fin_cnt;
    send(s, 6, -1, 0, lbc);
    @(negedge clk);
    #1;
    score_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_decision", decision, 0);
    chk("t6_rst_max", max_score, 0);
    chk("t6_rst_finish", finish, 0);
    chk("t6_rst_error", error, 0);
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    chk("t6_no_finish", fin_cnt, fb);
    foreach (s[i]) s[i] = score_t'(int'($urandom_range(0, 1999)) - 1000);
    s[7] = 24'sd4000;
    fb = fin_cnt;
    send(s, 10, 9, 0, lbc);
    drive(1'b0, '0, 1'b0);
    check_good("t6_after_rst", s, lbc, fb);
    chk("t6_error_clear", error, 0);

    // Beat 9 without score_last is a framing error
    foreach (s[i]) s[i] = score_t'($urandom);
    fb = fin_cnt;
    send(s, 10, -1, 0, lbc);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("t7_error", error, 1);
    chk("t7_no_finish", fin_cnt, fb);
    chk("t7_dec_held", decision, exp_dec);

    // Randomized good frames, some with forced ties and gaps
    for (int f = 0; f < 16; f++) begin
      foreach (s[i]) begin
        if ($urandom_range(0, 1) == 1) s[i] = score_t'(int'($urandom_range(0, 3)) - 2);
        else s[i] = score_t'($urandom);
      end
      fb = fin_cnt;
      send(s, 10, 9, int'($urandom_range(0, 2)), lbc);
      drive(1'b0, '0, 1'b0);
      check_good($sformatf("rnd%0d", f), s, lbc, fb);
    end

    chk("no_consecutive_finish", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
